// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with valid/ready TX, strobed RX, sync and error flags.
module uart_param #(
    parameter int CLKS_PER_BIT = 521,
    parameter int DATA_W       = 7,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_parity_bit
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] C_STOP = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS - 1);
    localparam logic HAS_PAR = PARITY != 0;
    localparam logic ODD     = PARITY == 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [IW-1:0]     tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              tx_par_q, tx_par_d, tx_out_q, tx_out_d;

    // The final stop period is one cycle short in STOP; the IDLE/accept cycle completes it,
    // so back-to-back frames are exactly one frame length apart.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid) begin
                    tx_state_d = START;
                    tx_sh_d    = tx_data;
                    tx_par_d   = ^tx_data ^ ODD;
                end
            end
            START: if (tx_cnt_q == C_LAST) begin
                tx_state_d = DATA;
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
            end
            DATA: if (tx_cnt_q == C_LAST) begin
                tx_cnt_d = '0;
                tx_sh_d  = tx_sh_q >> 1;
                tx_idx_d = tx_idx_q + IW'(1);
                if (tx_idx_q == I_LAST) begin
                    tx_state_d = HAS_PAR ? PAR : STOP;
                    tx_idx_d   = '0;
                end
            end
            PAR: if (tx_cnt_q == C_LAST) begin
                tx_state_d = STOP;
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
            end
            STOP: if (tx_idx_q == S_LAST && tx_cnt_q == C_STOP) begin
                tx_state_d = IDLE;
                tx_cnt_d   = '0;
            end else if (tx_cnt_q == C_LAST) begin
                tx_cnt_d = '0;
                tx_idx_d = tx_idx_q + IW'(1);
            end
            default: tx_state_d = IDLE;
        endcase
        tx_out_d = tx_state_d == START ? 1'b0 :
                   tx_state_d == DATA  ? tx_sh_d[0] :
                   tx_state_d == PAR   ? tx_par_d : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign tx_ready = tx_state_q == IDLE;
    assign tx_out   = tx_out_q;

    state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [IW-1:0]     rx_idx_q, rx_idx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic              rx_m_q, rx_s_q, rx_arm_q, rx_arm_d, rx_pcap_q, rx_pcap_d;
    logic              rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
    logic              rx_ferr_q, rx_ferr_d, rx_pbit_q, rx_pbit_d;

    // After a low stop sample the line must be seen high before a new start is honoured.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_arm_d   = rx_arm_q;
        rx_pcap_d  = rx_pcap_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_pbit_d  = rx_pbit_q;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d   = '0;
                rx_arm_d   = rx_arm_q | rx_s_q;
                rx_state_d = rx_arm_q && !rx_s_q ? START : IDLE;
            end
            START: if (rx_cnt_q == C_HALF) begin
                rx_state_d = rx_s_q ? IDLE : DATA;
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
            end
            DATA: if (rx_cnt_q == C_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s_q, rx_sh_q[DATA_W-1:1]};
                rx_idx_d = rx_idx_q + IW'(1);
                if (rx_idx_q == I_LAST) rx_state_d = HAS_PAR ? PAR : STOP;
            end
            PAR: if (rx_cnt_q == C_LAST) begin
                rx_state_d = STOP;
                rx_cnt_d   = '0;
                rx_pcap_d  = rx_s_q;
            end
            STOP: if (rx_cnt_q == C_LAST) begin
                rx_state_d = IDLE;
                rx_cnt_d   = '0;
                rx_valid_d = 1'b1;
                rx_data_d  = rx_sh_q;
                rx_pbit_d  = HAS_PAR & rx_pcap_q;
                rx_perr_d  = HAS_PAR & (^rx_sh_q ^ ODD ^ rx_pcap_q);
                rx_ferr_d  = !rx_s_q;
                rx_arm_d   = rx_s_q;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_arm_q   <= 1'b1;
            rx_pcap_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_pbit_q  <= 1'b0;
        end else begin
            rx_m_q     <= rx_in;
            rx_s_q     <= rx_m_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_arm_q   <= rx_arm_d;
            rx_pcap_q  <= rx_pcap_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_pbit_q  <= rx_pbit_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_bit = rx_pbit_q;
endmodule
